ece571_exec_wb_sequencer: RTL

//  Single-issue execute/write-back sequencer that sits directly upstream of the 16x32 register file.

---
 rtl/ece571_pkg.sv | 27 ++
 rtl/ece571_seq_mul.sv | 64 ++++++
 rtl/ece571_exec_wb_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ece571_pkg.sv
// Shared types and default widths for the execute/write-back sequencer.
package ece571_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 4;

   // ALU opcodes; the encoding is fixed because it arrives on a 3-bit bus.
   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SLL = 3'd5,
      OP_SRL = 3'd6,
      OP_MUL = 3'd7
   } op_e;

   // Sequencer FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MUL  = 2'd2,
      WB   = 2'd3
   } state_e;

endpackage

// File: rtl/ece571_seq_mul.sv
// Iterative shift-add multiplier returning the low DATA_W bits of a*b.
// One partial product is folded in per cycle for STEPS cycles after start.
// done and product are combinational during the final step so the owner
// can capture the result on the same edge that retires the last step.
module ece571_seq_mul
   import ece571_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int STEPS  = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   logic              running;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] acc_next;

   assign acc_next = acc + (mplier[0] ? mcand : '0);
   assign product  = acc_next;
   assign busy     = running;
   assign done     = running && (count == CNT_W'(STEPS - 1));

   // Control: run flag and step counter, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         running <= 1'b0;
         count   <= '0;
      end else if (start) begin
         running <= 1'b1;
         count   <= '0;
      end else if (running) begin
         count <= count + 1'b1;
         if (done) begin
            running <= 1'b0;
         end
      end
   end

   // Datapath: load operands on start, then shift and accumulate each step.
   always_ff @(posedge clk) begin
      if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
      end else if (running) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: rtl/ece571_exec_wb_sequencer.sv
// Single-issue execute/write-back sequencer in front of the register file.
// Accepts one instruction in IDLE, reads operands in EXEC, optionally runs
// the iterative multiplier, then issues a single write-back pulse in WB.
module ece571_exec_wb_sequencer
   import ece571_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MUL_STEPS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  op_e               in_op,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   output logic [ADDR_W-1:0] rf_read_addr1,
   output logic [ADDR_W-1:0] rf_read_addr2,
   input  logic [DATA_W-1:0] rf_read_data1,
   input  logic [DATA_W-1:0] rf_read_data2,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_we,
   output logic              busy,
   output logic              done
);

   localparam int SHW = $clog2(DATA_W);

   state_e            state;
   op_e               op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [ADDR_W-1:0] rs1_q;
   logic [ADDR_W-1:0] rs2_q;

   logic              mul_start;
   logic              mul_busy;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;

   // Single-cycle ALU; results wrap to DATA_W, shifts use the low SHW bits of b.
   function automatic logic [DATA_W-1:0] alu(input op_e op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      logic [SHW-1:0] sh;
      sh = b[SHW-1:0];
      case (op)
         OP_ADD:  alu = a + b;
         OP_SUB:  alu = a - b;
         OP_AND:  alu = a & b;
         OP_OR:   alu = a | b;
         OP_XOR:  alu = a ^ b;
         OP_SLL:  alu = a << sh;
         OP_SRL:  alu = a >> sh;
         default: alu = '0;
      endcase
   endfunction

   assign in_ready      = (state == IDLE);
   assign busy          = (state != IDLE);
   assign rf_read_addr1 = rs1_q;
   assign rf_read_addr2 = rs2_q;
   assign mul_start     = (state == EXEC) && (op_q == OP_MUL);

   ece571_seq_mul #(
      .DATA_W (DATA_W),
      .STEPS  (MUL_STEPS)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (rf_read_data1),
      .b       (rf_read_data2),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Sequencer FSM with instruction latch and registered write-back outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         op_q          <= OP_ADD;
         rd_q          <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rf_write_addr <= '0;
         rf_write_data <= '0;
         rf_we         <= 1'b0;
         done          <= 1'b0;
      end else begin
         rf_we <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q  <= in_op;
                  rd_q  <= in_rd;
                  rs1_q <= in_rs1;
                  rs2_q <= in_rs2;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (op_q == OP_MUL) begin
                  state <= MUL;
               end else begin
                  rf_write_addr <= rd_q;
                  rf_write_data <= alu(op_q, rf_read_data1, rf_read_data2);
                  rf_we         <= 1'b1;
                  done          <= 1'b1;
                  state         <= WB;
               end
            end
            MUL: begin
               if (mul_busy && mul_done) begin
                  rf_write_addr <= rd_q;
                  rf_write_data <= mul_product;
                  rf_we         <= 1'b1;
                  done          <= 1'b1;
                  state         <= WB;
               end
            end
            WB: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
